// File: rtl/prog_clock_scaler_pkg.sv
// Shared types, reset defaults and arithmetic helpers for the programmable clock scaler.
// Helpers operate on 32-bit values, so CNT_W must not exceed 32.
package prog_clock_scaler_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int N_CH_DEF  = 3;
    localparam int DIV_DEF   = 4096;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } run_state_e;

    // Evenly spread reset phase for channel idx.
    function automatic int unsigned default_phase(
        input int unsigned idx,
        input int unsigned div,
        input int unsigned n_ch
    );
        return (idx * div) / n_ch;
    endfunction

    // (a - b) mod m for a, b < m, without a divider.
    function automatic logic [31:0] mod_sub(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] m
    );
        if (a >= b) begin
            return a - b;
        end
        return m - (b - a);
    endfunction

endpackage

// File: rtl/pcs_phase_cmp.sv
// One output channel: phase-relative position within the period compared against duty.
module pcs_phase_cmp
    import prog_clock_scaler_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic [CNT_W-1:0] i_cnt,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_duty,
    input  logic [CNT_W-1:0] i_phase,
    output logic             o_high
);

    logic [31:0] w_rel;

    assign w_rel  = mod_sub(32'(i_cnt), 32'(i_phase), 32'(i_div));
    assign o_high = (w_rel < 32'(i_duty));

endmodule

// File: rtl/prog_clock_scaler.sv
// Shared period counter driving N_CH phase-shifted, duty-programmable clocks plus a period tick.
// Divisor, duty and phases are double-buffered and only take effect on a period boundary.
module prog_clock_scaler
    import prog_clock_scaler_pkg::*;
#(
    parameter int CNT_W        = CNT_W_DEF,
    parameter int N_CH         = N_CH_DEF,
    parameter int DIV_DEFAULT  = DIV_DEF,
    parameter int DUTY_DEFAULT = DIV_DEFAULT / 2
) (
    input  logic                  clk_in,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [CNT_W-1:0]      div_in,
    input  logic [CNT_W-1:0]      duty_in,
    input  logic [N_CH*CNT_W-1:0] phase_in,
    output logic [N_CH-1:0]       clk_out,
    output logic                  tick,
    output logic [CNT_W-1:0]      cnt_out,
    output logic                  pending,
    output logic                  cfg_err
);

    typedef logic [N_CH-1:0][CNT_W-1:0] phase_vec_t;

    function automatic phase_vec_t reset_phases();
        phase_vec_t p;
        p = '0;
        for (int i = 0; i < N_CH; i++) begin
            p[i] = CNT_W'(default_phase(i, DIV_DEFAULT, N_CH));
        end
        return p;
    endfunction

    localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DIV_DEFAULT);
    localparam logic [CNT_W-1:0] DUTY_RST  = CNT_W'(DUTY_DEFAULT);
    localparam phase_vec_t       PHASE_RST = reset_phases();

    run_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_tick;
    logic [N_CH-1:0]  r_clk_out;
    logic             r_pending;
    logic             r_cfg_err;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_duty;
    phase_vec_t       r_phase;
    logic [CNT_W-1:0] r_sh_div;
    logic [CNT_W-1:0] r_sh_duty;
    phase_vec_t       r_sh_phase;

    run_state_e       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_tick_nxt;
    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic             w_cfg_err_nxt;
    logic             w_pending_nxt;
    phase_vec_t       w_phase_in;
    logic [CNT_W-1:0] w_div_nxt;
    logic [CNT_W-1:0] w_duty_nxt;
    phase_vec_t       w_phase_nxt;
    logic [N_CH-1:0]  w_high;
    logic [N_CH-1:0]  w_clk_nxt;

    // Load validation happens against the requested divisor, not the active one.
    always_comb begin
        w_phase_in = '0;
        w_load_ok  = load && (div_in >= CNT_W'(2)) && (duty_in <= div_in);
        for (int i = 0; i < N_CH; i++) begin
            w_phase_in[i] = phase_in[i*CNT_W +: CNT_W];
            if (w_phase_in[i] >= div_in) begin
                w_load_ok = 1'b0;
            end
        end
        w_cfg_err_nxt = load && !w_load_ok;
    end

    // Defensive: any count at or beyond the last slot wraps.
    assign w_wrap = (r_cnt >= (r_div - CNT_W'(1)));

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_tick_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en) begin
                    w_state_nxt = ST_RUN;
                    w_tick_nxt  = 1'b1;
                end
            end
            ST_RUN: begin
                if (!en) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_wrap) begin
                    w_tick_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // A load in the apply cycle only reaches the shadow; the older shadow is what applies.
    assign w_apply       = r_pending && (!en || ((r_state == ST_RUN) && w_wrap));
    assign w_pending_nxt = w_load_ok ? 1'b1 : (w_apply ? 1'b0 : r_pending);
    assign w_div_nxt     = w_apply ? r_sh_div   : r_div;
    assign w_duty_nxt    = w_apply ? r_sh_duty  : r_duty;
    assign w_phase_nxt   = w_apply ? r_sh_phase : r_phase;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        pcs_phase_cmp #(
            .CNT_W (CNT_W)
        ) u_cmp (
            .i_cnt   (w_cnt_nxt),
            .i_div   (w_div_nxt),
            .i_duty  (w_duty_nxt),
            .i_phase (w_phase_nxt[g]),
            .o_high  (w_high[g])
        );
    end

    assign w_clk_nxt = (w_state_nxt == ST_RUN) ? w_high : '0;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_tick     <= 1'b0;
            r_clk_out  <= '0;
            r_pending  <= 1'b0;
            r_cfg_err  <= 1'b0;
            r_div      <= DIV_RST;
            r_duty     <= DUTY_RST;
            r_phase    <= PHASE_RST;
            r_sh_div   <= DIV_RST;
            r_sh_duty  <= DUTY_RST;
            r_sh_phase <= PHASE_RST;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_tick    <= w_tick_nxt;
            r_clk_out <= w_clk_nxt;
            r_pending <= w_pending_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_div     <= w_div_nxt;
            r_duty    <= w_duty_nxt;
            r_phase   <= w_phase_nxt;
            if (w_load_ok) begin
                r_sh_div   <= div_in;
                r_sh_duty  <= duty_in;
                r_sh_phase <= w_phase_in;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign tick    = r_tick;
    assign cnt_out = r_cnt;
    assign pending = r_pending;
    assign cfg_err = r_cfg_err;

endmodule
